sa3_tile_sequencer: RTL and testbench
=====================================

Name: sa3_tile_sequencer

Overview:
- Initiator and feeder for the 3x3 systolic convolution engine.
- Accepts a serial byte stream containing one 3x3 filter and one 4x4 input tile, and registers them onto the engine's parallel operand buses.
- Drives the engine's active strobe until the engine reports done, captures the four 2x2 results, and streams them out serially with valid/ready.
- Sits between the tile/weight fetch logic and the systolic engine.

Parameters:
- TIMEOUT_CYC, 32, maximum number of RUN cycles to wait for done_sa3 before aborting (the engine needs 17).
- TO_W, 6, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream byte valid.
- in_data  in  8  upstream byte.
- in_ready  out  1  sequencer can accept a byte.
- a_bus  out  128  input tile a11..a44, row-major; a11 = [7:0], a12 = [15:8], ..., a44 = [127:120].
- b_bus  out  72  filter b11..b33, row-major; b11 = [7:0], ..., b33 = [71:64].
- active_sa3  out  1  engine run request.
- done_sa3  in  1  engine completion, one-cycle combinational pulse.
- c11, c12, c21, c22  in  8 each  engine results.
- out_valid  out  1  result byte valid.
- out_data  out  8  result byte.
- out_ready  in  1  downstream accepts the result byte.
- out_last  out  1  high with the 4th result byte (c22).
- err_timeout  out  1  one-cycle pulse when a run is aborted.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state = LOAD, byte counter = 0, timeout counter = 0;
  - a_bus = 0, b_bus = 0, captured results = 0;
  - active_sa3 = 0, out_valid = 0, out_last = 0, out_data = 0, err_timeout = 0.
- While rst is high, in_ready = 0.
- in_ready = 1 exactly when state == LOAD; it is decoded from the state register.
- LOAD:
  - A byte is accepted on each clock edge where in_valid && in_ready.
  - Counter 0..24 selects the destination:
    - bytes 0..8 go to b11, b12, b13, b21, ..., b33;
    - bytes 9..24 go to a11, a12, ..., a44.
  - Gaps in in_valid stall the counter; nothing is lost.
  - On acceptance of byte 24: counter returns to 0, state goes to RUN, and active_sa3 = 1 from the next cycle.
- RUN:
  - active_sa3 is held at 1 continuously; a_bus and b_bus are held stable.
  - The timeout counter increments every cycle.
  - On an edge with done_sa3 = 1:
    - c11, c12, c21, c22 are captured into result registers;
    - active_sa3 = 0 on the following cycle, so the engine parks in its idle state and does not restart;
    - state goes to DRAIN.
  - If the counter reaches TIMEOUT_CYC without done_sa3:
    - active_sa3 = 0;
    - err_timeout pulses for one cycle;
    - no results are emitted;
    - state goes to LOAD; operand buses keep their old values until overwritten.
  - If done_sa3 and timeout occur on the same edge, done wins.
- DRAIN:
  - Emits the captured c11, c12, c21, c22 in that order.
  - out_valid is asserted the cycle after DRAIN entry.
  - out_data and out_last are held stable while out_valid && !out_ready.
  - The next byte is presented on the cycle after each handshake.
  - out_last = 1 only with c22.
  - After the c22 handshake: out_valid = 0, state goes to LOAD.
- done_sa3 is ignored outside RUN.
- Latency from the last input byte to the first out_valid = engine latency (17 cycles) + 2.
- No arithmetic is done here; results pass through as 8 bits, unmodified.
- Operand buses never change while active_sa3 = 1.
- Reset mid-RUN or mid-DRAIN aborts immediately to the reset values; captured results are discarded.

Test Plan:
- Load filter bytes 1..9, then tile bytes 10..25 → b_bus[7:0] = 1, b_bus[71:64] = 9, a_bus[7:0] = 10, a_bus[127:120] = 25; active_sa3 rises the cycle after byte 24.
- Behavioural engine stub pulses done_sa3 17 cycles after active, with c = 0x11, 0x22, 0x33, 0x44, and out_ready held at 1 → out_data sequence 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles; out_last only on 0x44; active_sa3 low the cycle after done.
- Same stimulus with out_ready toggling 1-0-0-1 → each byte held while stalled; exactly 4 handshakes; in_ready stays 0 until the c22 handshake completes.
- Stub never asserts done → err_timeout pulses once after 32 RUN cycles; active_sa3 drops; no out_valid; in_ready = 1 on the next cycle.
- in_valid asserted only every 3rd cycle across the full 25-byte load → all bytes land in the correct slots; active_sa3 is asserted only after byte 24.
- Assert rst for 1 cycle at RUN cycle 5 → active_sa3 = 0, a_bus = 0, and in_ready = 1 the cycle after rst falls; a following full load/run completes normally.

Source files
------------

// File: rtl/sa3_tile_sequencer.sv
// Loads one 3x3 filter and one 4x4 tile from a byte stream, runs the 3x3 systolic
// engine until done (or timeout), then streams the four 2x2 results out with valid/ready.
`default_nettype none

module sa3_tile_sequencer #(
  parameter int TIMEOUT_CYC = 32,
  parameter int TO_W        = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic [127:0] a_bus,
  output logic [71:0]  b_bus,
  output logic         active_sa3,
  input  logic         done_sa3,
  input  logic [7:0]   c11,
  input  logic [7:0]   c12,
  input  logic [7:0]   c21,
  input  logic [7:0]   c22,
  output logic         out_valid,
  output logic [7:0]   out_data,
  input  logic         out_ready,
  output logic         out_last,
  output logic         err_timeout
);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [4:0]      byte_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [1:0]      drain_idx;
  logic [7:0]      res [4];

  logic accept;
  logic handshake;
  logic to_hit;

  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;
  assign to_hit    = (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_LOAD;
    else     state <= state_nxt;
  end

  // done_sa3 takes priority over an expiring timeout on the same edge
  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:  if (accept && byte_cnt == 5'd24) state_nxt = S_RUN;
      S_RUN: begin
        if (done_sa3)    state_nxt = S_DRAIN;
        else if (to_hit) state_nxt = S_LOAD;
      end
      S_DRAIN: if (handshake && drain_idx == 2'd3) state_nxt = S_LOAD;
      default: state_nxt = S_LOAD;
    endcase
  end

  always_comb begin
    in_ready   = (state == S_LOAD) && !rst;
    active_sa3 = (state == S_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt    <= '0;
      to_cnt      <= '0;
      drain_idx   <= '0;
      a_bus       <= '0;
      b_bus       <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      err_timeout <= 1'b0;
      for (int i = 0; i < 4; i++) res[i] <= '0;
    end else begin
      err_timeout <= (state == S_RUN) && !done_sa3 && to_hit;

      if (state == S_RUN && !done_sa3 && !to_hit) to_cnt <= to_cnt + 1'b1;
      else                                        to_cnt <= '0;

      if (accept) begin
        for (int i = 0; i < 9; i++)
          if (byte_cnt == 5'(i)) b_bus[i*8 +: 8] <= in_data;
        for (int i = 0; i < 16; i++)
          if (byte_cnt == 5'(i + 9)) a_bus[i*8 +: 8] <= in_data;
        byte_cnt <= (byte_cnt == 5'd24) ? 5'd0 : byte_cnt + 5'd1;
      end

      if (state == S_RUN && done_sa3) begin
        res[0] <= c11;
        res[1] <= c12;
        res[2] <= c21;
        res[3] <= c22;
      end

      // drain_idx names the result currently presented on out_data
      if (state == S_DRAIN) begin
        if (!out_valid) begin
          out_valid <= 1'b1;
          out_data  <= res[drain_idx];
          out_last  <= (drain_idx == 2'd3);
        end else if (handshake) begin
          if (drain_idx == 2'd3) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            drain_idx <= '0;
          end else begin
            drain_idx <= drain_idx + 2'd1;
            out_data  <= res[drain_idx + 2'd1];
            out_last  <= (drain_idx == 2'd2);
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sa3_tile_sequencer.sv
// Randomized bench for sa3_tile_sequencer with a behavioural engine stub and a
// transaction-level reference (expected buses and result stream) built from the byte lists.
`default_nettype none

module tb_sa3_tile_sequencer;

  localparam int TIMEOUT_CYC = 32;
  localparam int DONE_AT     = 17;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic [127:0] a_bus;
  logic [71:0]  b_bus;
  logic         active_sa3;
  logic         done_sa3;
  logic [7:0]   c11, c12, c21, c22;
  logic         out_valid;
  logic [7:0]   out_data;
  logic         out_ready;
  logic         out_last;
  logic         err_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  logic         stub_en;
  int           act_cnt;
  logic [7:0]   cres [4];
  logic [127:0] exp_a;
  logic [71:0]  exp_b;

  sa3_tile_sequencer #(.TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .a_bus(a_bus), .b_bus(b_bus), .active_sa3(active_sa3), .done_sa3(done_sa3),
    .c11(c11), .c12(c12), .c21(c21), .c22(c22), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .out_last(out_last), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Engine stub: combinational done pulse a fixed number of cycles into the run
  always @(posedge clk) act_cnt <= active_sa3 ? act_cnt + 1 : 0;
  assign done_sa3 = stub_en && active_sa3 && (act_cnt == DONE_AT);
  assign c11 = cres[0];
  assign c12 = cres[1];
  assign c21 = cres[2];
  assign c22 = cres[3];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Feed 25 bytes (fixed 1..25 or random) with gaps; builds expected operand buses.
  task automatic load(input bit fixed, input bit gappy);
    logic [7:0] bytes [25];
    for (int k = 0; k < 25; k++) bytes[k] = fixed ? 8'(k + 1) : 8'($urandom);
    for (int i = 0; i < 9; i++)  exp_b[i*8 +: 8] = bytes[i];
    for (int i = 0; i < 16; i++) exp_a[i*8 +: 8] = bytes[9 + i];
    for (int k = 0; k < 25; k++) begin
      int gaps;
      gaps = gappy ? 2 : int'($urandom_range(0, 2));
      repeat (gaps) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        chk("idle_during_load", {126'd0, active_sa3, out_valid}, 128'd0);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = bytes[k];
      chk("in_ready_load", {127'd0, in_ready}, 128'd1);
      if (k == 24) chk("active_before_last", {127'd0, active_sa3}, 128'd0);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("active_after_last", {127'd0, active_sa3}, 128'd1);
    chk("in_ready_run", {127'd0, in_ready}, 128'd0);
    chk("b_bus", {56'd0, b_bus}, {56'd0, exp_b});
    chk("a_bus", a_bus, exp_a);
  endtask

  // Run until done or timeout, then drain. ready_mode: 0 always, 1 pattern 1-0-0-1, 2 random.
  task automatic run_and_drain(input bit expect_done, input int ready_mode);
    int act_cycles;
    bit fin;
    logic [7:0] q [$];
    int hs;
    int iters;
    act_cycles = 0;
    fin = 0;
    for (int t = 0; t < 80 && !fin; t++) begin
      if (active_sa3) begin
        act_cycles++;
        chk("bus_stable_a", a_bus, exp_a);
      end
      if (expect_done && done_sa3) begin
        @(negedge clk);
        chk("active_after_done", {127'd0, active_sa3}, 128'd0);
        chk("drain_entry_valid", {127'd0, out_valid}, 128'd0);
        fin = 1;
      end else if (!expect_done && !active_sa3) begin
        chk("timeout_cycles", 128'(act_cycles), 128'(TIMEOUT_CYC));
        chk("err_timeout_hi", {127'd0, err_timeout}, 128'd1);
        chk("timeout_no_valid", {127'd0, out_valid}, 128'd0);
        chk("timeout_in_ready", {127'd0, in_ready}, 128'd1);
        @(negedge clk);
        chk("err_timeout_pulse", {127'd0, err_timeout}, 128'd0);
        chk("timeout_no_valid2", {127'd0, out_valid}, 128'd0);
        fin = 1;
      end else begin
        chk("no_err_in_run", {127'd0, err_timeout}, 128'd0);
        @(negedge clk);
      end
    end
    chk("run_bound", {127'd0, fin}, 128'd1);
    if (!expect_done || !fin) return;

    for (int i = 0; i < 4; i++) q.push_back(cres[i]);
    hs = 0;
    iters = 0;
    @(negedge clk);
    for (int t = 0; t < 200 && q.size() > 0; t++) begin
      iters++;
      chk("in_ready_drain", {127'd0, in_ready}, 128'd0);
      chk("drain_valid", {127'd0, out_valid}, 128'd1);
      if (out_valid) begin
        chk("out_data", {120'd0, out_data}, {120'd0, q[0]});
        chk("out_last", {127'd0, out_last}, {127'd0, q.size() == 1});
      end
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (t % 4 == 0) || (t % 4 == 3);
        default: out_ready = 1'($urandom);
      endcase
      if (out_valid && out_ready) begin
        void'(q.pop_front());
        hs++;
      end
      @(negedge clk);
    end
    chk("handshakes", 128'(hs), 128'd4);
    if (ready_mode == 0) chk("drain_back_to_back", 128'(iters), 128'd4);
    chk("valid_after_drain", {127'd0, out_valid}, 128'd0);
    chk("in_ready_after_drain", {127'd0, in_ready}, 128'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; stub_en = 1'b0;
    for (int i = 0; i < 4; i++) cres[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd0);
    chk("rst_a_bus", a_bus, 128'd0);
    chk("rst_b_bus", {56'd0, b_bus}, 128'd0);
    chk("rst_outs", {116'd0, active_sa3, out_valid, out_last, err_timeout, out_data},
        128'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {127'd0, in_ready}, 128'd1);

    // Directed: fixed bytes, results 11..44, ready held high
    cres[0] = 8'h11; cres[1] = 8'h22; cres[2] = 8'h33; cres[3] = 8'h44;
    stub_en = 1'b1;
    load(1'b1, 1'b0);
    chk("b11", {120'd0, b_bus[7:0]}, 128'd1);
    chk("a44", {120'd0, a_bus[127:120]}, 128'd25);
    run_and_drain(1'b1, 0);

    // Same with stalling downstream
    load(1'b1, 1'b0);
    run_and_drain(1'b1, 1);

    // Timeout: engine never finishes
    stub_en = 1'b0;
    load(1'b0, 1'b0);
    run_and_drain(1'b0, 0);

    // Sparse upstream: a byte every third cycle
    stub_en = 1'b1;
    for (int i = 0; i < 4; i++) cres[i] = 8'($urandom);
    load(1'b0, 1'b1);
    run_and_drain(1'b1, 2);

    // Reset in the middle of a run
    load(1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrun_rst_in_ready", {127'd0, in_ready}, 128'd0);
    chk("midrun_rst_active", {127'd0, active_sa3}, 128'd0);
    chk("midrun_rst_a_bus", a_bus, 128'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("after_rst_no_valid", {127'd0, out_valid}, 128'd0);

    // Randomized transactions
    for (int n = 0; n < 20; n++) begin
      bit done_mode;
      done_mode = ($urandom_range(0, 4) != 0);
      stub_en = done_mode;
      for (int i = 0; i < 4; i++) cres[i] = 8'($urandom);
      load(1'b0, 1'($urandom_range(0, 3) == 0));
      run_and_drain(done_mode, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule

`default_nettype wire
